// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS datapath: walks each instruction through
// fetch/decode/execute/memory/write-back and drives every datapath select and strobe.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic        reg_dst_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  pc_src_o,
  output logic        branch_eq_o,
  output logic        branch_ne_o,
  output logic        illegal_op_o,
  output logic [3:0]  state_o,
  output logic [15:0] retired_o
);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpOri  = 6'h0D;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpBne  = 6'h05;
  localparam logic [5:0] OpJ    = 6'h02;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StBranch  = 4'd5,
    StJump    = 4'd6,
    StWbR     = 4'd7,
    StWbI     = 4'd8,
    StMemRd   = 4'd9,
    StMemWr   = 4'd10,
    StWbMem   = 4'd11
  } state_e;

  state_e      r_state;
  state_e      w_next;
  logic [5:0]  r_opcode;
  logic [15:0] r_retired;
  logic        w_retire;
  logic        w_illegal;

  always_comb begin
    w_next    = StFetch;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      StFetch:   w_next = mem_ready_i ? StDecode : StFetch;
      StDecode: begin
        case (opcode_i)
          OpR:           w_next = StExecR;
          OpAddi, OpOri: w_next = StExecI;
          OpLw, OpSw:    w_next = StMemAddr;
          OpBeq, OpBne:  w_next = StBranch;
          OpJ:           w_next = StJump;
          default: begin
            w_next    = StFetch;
            w_illegal = 1'b1;
          end
        endcase
      end
      StExecR:   w_next = StWbR;
      StExecI:   w_next = StWbI;
      StMemAddr: w_next = (r_opcode == OpLw) ? StMemRd : StMemWr;
      StBranch, StJump, StWbR, StWbI, StWbMem: begin
        w_next   = StFetch;
        w_retire = 1'b1;
      end
      StMemRd:   w_next = mem_ready_i ? StWbMem : StMemRd;
      StMemWr: begin
        w_next   = mem_ready_i ? StFetch : StMemWr;
        w_retire = mem_ready_i;
      end
      default:   w_next = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StFetch;
      r_opcode  <= 6'h00;
      r_retired <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == StDecode) r_opcode <= opcode_i;
      if (w_retire) r_retired <= r_retired + 16'd1;
    end
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    pc_src_o     = 2'b00;
    branch_eq_o  = 1'b0;
    branch_ne_o  = 1'b0;
    illegal_op_o = 1'b0;
    case (r_state)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = 3'b100;
        pc_write_o  = mem_ready_i;
        ir_write_o  = mem_ready_i;
      end
      StDecode: begin
        alu_src_b_o  = 2'b11;
        alu_op_o     = 3'b100;
        illegal_op_o = w_illegal;
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b111;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (r_opcode == OpOri) ? 3'b001 : 3'b100;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 3'b100;
      end
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
        pc_src_o    = 2'b01;
        branch_eq_o = (r_opcode == OpBeq);
        branch_ne_o = (r_opcode == OpBne);
      end
      StJump: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
      end
      StWbR: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      StWbI:   reg_write_o = 1'b1;
      StMemRd: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      StMemWr: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      StWbMem: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      default: ;
    endcase
    // Reset must suppress every side effect, even when it lands mid-instruction.
    if (reset) begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      illegal_op_o = 1'b0;
    end
  end

  assign state_o   = r_state;
  assign retired_o = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench for multicycle_control against a per-instruction
// reference model that expands each opcode into its expected cycle-by-cycle schedule.
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode_i;
  logic        mem_ready_i;
  logic        pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o;
  logic        mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0]  alu_src_b_o, pc_src_o;
  logic [2:0]  alu_op_o;
  logic        branch_eq_o, branch_ne_o, illegal_op_o;
  logic [3:0]  state_o;
  logic [15:0] retired_o;

  int          n_tests;
  int          n_fail;
  logic [15:0] model_ret;

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_i     (opcode_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .ir_write_o   (ir_write_o),
    .i_or_d_o     (i_or_d_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_dst_o    (reg_dst_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .pc_src_o     (pc_src_o),
    .branch_eq_o  (branch_eq_o),
    .branch_ne_o  (branch_ne_o),
    .illegal_op_o (illegal_op_o),
    .state_o      (state_o),
    .retired_o    (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [18:0] w_obs = {pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
                       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                       alu_op_o, pc_src_o, branch_eq_o, branch_ne_o, illegal_op_o};

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  endfunction

  // Expected output vector for a given state, opcode and live ready/reset.
  function automatic logic [18:0] exp_out(input int st, input logic [5:0] op,
                                          input logic rdy, input logic rst);
    logic pcw, irw, iord, mr, mw, m2r, rdst, rw, asa, beq, bne, ill;
    logic [1:0] asb, psrc;
    logic [2:0] aop;
    {pcw, irw, iord, mr, mw, m2r, rdst, rw, asa, beq, bne, ill} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mr = 1; asb = 2'b01; aop = 3'b100; pcw = rdy; irw = rdy; end
      1:  begin asb = 2'b11; aop = 3'b100; ill = !is_legal(op); end
      2:  begin asa = 1; aop = 3'b111; end
      3:  begin asa = 1; asb = 2'b10; aop = (op == 6'h08) ? 3'b100 : 3'b001; end
      4:  begin asa = 1; asb = 2'b10; aop = 3'b100; end
      5:  begin asa = 1; aop = 3'b010; psrc = 2'b01; beq = (op == 6'h04); bne = (op == 6'h05); end
      6:  begin psrc = 2'b10; pcw = 1; end
      7:  begin rdst = 1; rw = 1; end
      8:  rw = 1;
      9:  begin mr = 1; iord = 1; end
      10: begin mw = 1; iord = 1; end
      11: begin m2r = 1; rw = 1; end
      default: ;
    endcase
    if (rst) {pcw, irw, mr, mw, rw, ill} = '0;
    return {pcw, irw, iord, mr, mw, m2r, rdst, rw, asa, asb, aop, psrc, beq, bne, ill};
  endfunction

  // Runs one instruction with fw fetch waits and mw memory waits; optionally
  // asserts reset at step abort_step and checks that the instruction is abandoned.
  task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                           input int mw, input int abort_step);
    int   sts[$];
    logic rdys[$];
    logic [18:0] exp;
    for (int i = 0; i <= fw; i++) begin sts.push_back(0); rdys.push_back(i == fw); end
    sts.push_back(1); rdys.push_back(1'($urandom));
    case (op)
      6'h00: begin sts.push_back(2); sts.push_back(7); end
      6'h08, 6'h0D: begin sts.push_back(3); sts.push_back(8); end
      6'h04, 6'h05: sts.push_back(5);
      6'h02: sts.push_back(6);
      6'h23, 6'h2B: sts.push_back(4);
      default: ;
    endcase
    while (rdys.size() < sts.size()) rdys.push_back(1'($urandom));
    if (op == 6'h23 || op == 6'h2B) begin
      for (int i = 0; i <= mw; i++) begin
        sts.push_back(op == 6'h23 ? 9 : 10);
        rdys.push_back(i == mw);
      end
      if (op == 6'h23) begin sts.push_back(11); rdys.push_back(1'($urandom)); end
    end
    for (int i = 0; i < sts.size(); i++) begin
      @(negedge clk);
      opcode_i    = (sts[i] == 1) ? op : 6'($urandom);
      mem_ready_i = rdys[i];
      if (i == abort_step) reset = 1'b1;
      #1;
      exp = exp_out(sts[i], op, rdys[i], i == abort_step);
      n_tests++;
      if (state_o !== 4'(sts[i])) begin
        n_fail++;
        $display("FAIL %s state step %0d: got %0d want %0d", name, i, state_o, sts[i]);
      end
      n_tests++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL %s outputs step %0d: got %b want %b", name, i, w_obs, exp);
      end
      n_tests++;
      if (retired_o !== model_ret) begin
        n_fail++;
        $display("FAIL %s retired step %0d: got %0d want %0d", name, i, retired_o, model_ret);
      end
      if (i == abort_step) begin
        @(negedge clk);
        reset       = 1'b0;
        mem_ready_i = 1'b0;
        model_ret   = 16'h0000;
        n_tests++;
        if (state_o !== 4'd0 || retired_o !== 16'h0000) begin
          n_fail++;
          $display("FAIL %s after reset: got state %0d retired %0d want 0 0",
                   name, state_o, retired_o);
        end
        return;
      end
    end
    if (is_legal(op)) model_ret = model_ret + 16'd1;
  endtask

  task automatic test_reset();
    logic [18:0] exp;
    reset       = 1'b1;
    mem_ready_i = 1'b1;
    opcode_i    = 6'h00;
    repeat (3) @(negedge clk);
    #1;
    exp = exp_out(0, 6'h00, 1'b1, 1'b1);
    n_tests++;
    if (state_o !== 4'd0 || retired_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset state: got %0d/%0d want 0/0", state_o, retired_o);
    end
    n_tests++;
    if (w_obs !== exp) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want %b", w_obs, exp);
    end
    reset       = 1'b0;
    mem_ready_i = 1'b0;
    model_ret   = 16'h0000;
  endtask

  task automatic test_addi();
    run_instr("addi", 6'h08, 0, 0, -1);
  endtask

  task automatic test_lw_waits();
    run_instr("lw_waits", 6'h23, 2, 3, -1);
  endtask

  task automatic test_bne_j();
    run_instr("bne", 6'h05, 0, 0, -1);
    run_instr("j", 6'h02, 0, 0, -1);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 6'h3F, 0, 0, -1);
    run_instr("illegal_after", 6'h0D, 1, 0, -1);
  endtask

  task automatic test_reset_mid_memwr();
    run_instr("r_before", 6'h00, 0, 0, -1);
    // SW with 3 waits: FETCH, DECODE, MEM_ADDR, then MEM_WR at step 3 not ready.
    run_instr("reset_memwr", 6'h2B, 0, 3, 4);
    run_instr("after_reset", 6'h04, 0, 0, -1);
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    mem_ready_i = 1'b0;
    force dut.r_retired = 16'hFFFF;
    #1;
    release dut.r_retired;
    model_ret = 16'hFFFF;
    run_instr("wrap_sw", 6'h2B, 0, 1, -1);
    run_instr("wrap_after", 6'h02, 0, 0, -1);
    n_tests++;
    if (model_ret !== 16'h0001 || retired_o === 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap: got %0d want model %0d", retired_o, model_ret);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    model_ret   = 16'h0000;
    reset       = 1'b1;
    opcode_i    = 6'h00;
    mem_ready_i = 1'b0;
    test_reset();
    test_addi();
    test_lw_waits();
    test_bne_j();
    test_illegal();
    test_reset_mid_memwr();
    test_random();
    test_wrap();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
